// File: rtl/jtopl_reg_pkg.sv
// Shared constants and the data-write decode helper for the OPL register front end.
package jtopl_reg_pkg;

  localparam logic [3:0] REG_FNUMLO = 4'hA;
  localparam logic [3:0] REG_FNUMHI = 4'hB;
  localparam logic [3:0] REG_FBCON  = 4'hC;
  localparam logic [7:0] REG_RHY    = 8'hBD;
  localparam logic [7:0] REG_TEST   = 8'h01;

  localparam logic [3:0] CH_MAX = 4'd8;

  localparam int SUBS   = 6;
  localparam int GROUPS = 3;
  localparam int SLOTS  = 18;

  typedef enum logic [1:0] {
    UP_NONE,
    UP_FNUMLO,
    UP_FNUMHI,
    UP_FBCON
  } up_kind_e;

  // Per-channel registers only exist for channels 0..CH_MAX; anything above is dropped.
  function automatic up_kind_e decode_up(input logic [7:0] reg_addr);
    up_kind_e kind;
    kind = UP_NONE;
    if (reg_addr[3:0] <= CH_MAX) begin
      case (reg_addr[7:4])
        REG_FNUMLO: kind = UP_FNUMLO;
        REG_FNUMHI: kind = UP_FNUMHI;
        REG_FBCON:  kind = UP_FBCON;
        default:    kind = UP_NONE;
      endcase
    end
    return kind;
  endfunction

endpackage

// File: rtl/jtopl_reg_dec_if.sv
// CPU-side write bus of the OPL register front end.
interface jtopl_reg_dec_if;
  logic       wr_n;
  logic       addr;
  logic [7:0] din;
  logic       busy;

  modport master (output wr_n, output addr, output din, input busy);
  modport slave  (input wr_n, input addr, input din, output busy);
endinterface

// File: rtl/jtopl_slot_cnt.sv
// 18-slot timing sequencer: group 0..2, sub 0..5, one-hot slot and zero marker.
module jtopl_slot_cnt
  import jtopl_reg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  output logic [1:0]       group,
  output logic [2:0]       sub,
  output logic [SLOTS-1:0] slot,
  output logic             zero
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      group <= 2'd0;
      sub   <= 3'd0;
      slot  <= SLOTS'(1);
    end else if (cen) begin
      if (sub == 3'(SUBS - 1)) begin
        sub   <= 3'd0;
        group <= (group == 2'(GROUPS - 1)) ? 2'd0 : group + 2'd1;
      end else begin
        sub <= sub + 3'd1;
      end
      slot <= {slot[SLOTS-2:0], slot[SLOTS-1]};
    end
  end

  assign zero = (group == 2'd0) && (sub == 3'd0);

endmodule

// File: rtl/jtopl_reg_dec.sv
// OPL register write decoder: busy hold-off, per-channel update strobes, 0xBD globals.
// Optional macro JTOPL_WAVSEL_EN enables the waveform-select bit in register 0x01.
module jtopl_reg_dec
  import jtopl_reg_pkg::*;
#(
  parameter int BUSY_CEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  jtopl_reg_dec_if.slave   bus,
  output logic [3:0]       up_ch,
  output logic             up_fnumlo,
  output logic             up_fnumhi,
  output logic             up_fbcon,
  output logic [7:0]       up_din,
  output logic             rhy_en,
  output logic [4:0]       rhy_kon,
  output logic             am_dep,
  output logic             vib_dep,
  output logic             wav_en,
  output logic [1:0]       group,
  output logic [2:0]       sub,
  output logic [SLOTS-1:0] slot,
  output logic             zero
);

  logic [7:0] selreg;
  logic [3:0] busy_cnt;
  logic       busy;
  logic       addr_wr;
  logic       data_wr;
  up_kind_e   kind;

  assign addr_wr  = !bus.wr_n && !bus.addr;
  assign data_wr  = !bus.wr_n &&  bus.addr && !busy;
  assign kind     = decode_up(selreg);
  assign bus.busy = busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      selreg    <= 8'd0;
      busy      <= 1'b0;
      busy_cnt  <= 4'd0;
      up_ch     <= 4'd0;
      up_din    <= 8'd0;
      up_fnumlo <= 1'b0;
      up_fnumhi <= 1'b0;
      up_fbcon  <= 1'b0;
      {am_dep, vib_dep, rhy_en, rhy_kon} <= 8'd0;
    end else begin
      if (addr_wr) selreg <= bus.din;

      if (cen) begin
        up_fnumlo <= 1'b0;
        up_fnumhi <= 1'b0;
        up_fbcon  <= 1'b0;
      end

      if (busy && cen) begin
        busy_cnt <= busy_cnt - 4'd1;
        if (busy_cnt == 4'd1) busy <= 1'b0;
      end

      // NOTE: this block comes last on purpose; a write edge overrides the cen clear above,
      // so a write coinciding with cen neither loses its strobe nor counts that cen.
      if (data_wr) begin
        busy      <= 1'b1;
        busy_cnt  <= 4'(BUSY_CEN);
        up_din    <= bus.din;
        up_ch     <= selreg[3:0];
        up_fnumlo <= (kind == UP_FNUMLO);
        up_fnumhi <= (kind == UP_FNUMHI);
        up_fbcon  <= (kind == UP_FBCON);
        if (selreg == REG_RHY) {am_dep, vib_dep, rhy_en, rhy_kon} <= bus.din;
      end
    end
  end

`ifdef JTOPL_WAVSEL_EN
  always_ff @(posedge clk) begin
    if (rst)                                 wav_en <= 1'b0;
    else if (data_wr && selreg == REG_TEST)  wav_en <= bus.din[5];
  end
`else
  assign wav_en = 1'b0;
`endif

  jtopl_slot_cnt u_slot_cnt (
    .clk   (clk),
    .rst   (rst),
    .cen   (cen),
    .group (group),
    .sub   (sub),
    .slot  (slot),
    .zero  (zero)
  );

endmodule

// File: tb/tb_jtopl_reg_dec.sv
// Directed self-checking bench for jtopl_reg_dec (BUSY_CEN=4).
module tb_jtopl_reg_dec;

  logic        clk;
  logic        rst;
  logic        cen;
  logic [3:0]  up_ch;
  logic        up_fnumlo, up_fnumhi, up_fbcon;
  logic [7:0]  up_din;
  logic        rhy_en, am_dep, vib_dep, wav_en, zero;
  logic [4:0]  rhy_kon;
  logic [1:0]  group;
  logic [2:0]  sub;
  logic [17:0] slot;

  int checks   = 0;
  int failures = 0;

  jtopl_reg_dec_if bus ();

  jtopl_reg_dec #(.BUSY_CEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .bus       (bus),
    .up_ch     (up_ch),
    .up_fnumlo (up_fnumlo),
    .up_fnumhi (up_fnumhi),
    .up_fbcon  (up_fbcon),
    .up_din    (up_din),
    .rhy_en    (rhy_en),
    .rhy_kon   (rhy_kon),
    .am_dep    (am_dep),
    .vib_dep   (vib_dep),
    .wav_en    (wav_en),
    .group     (group),
    .sub       (sub),
    .slot      (slot),
    .zero      (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input logic c);
    cen = c;
    @(posedge clk);
    #1;
    cen = 1'b0;
  endtask

  task automatic cpu_wr(input logic a, input logic [7:0] d, input logic c);
    bus.addr = a;
    bus.din  = d;
    bus.wr_n = 1'b0;
    cen      = c;
    @(posedge clk);
    #1;
    bus.wr_n = 1'b1;
    cen      = 1'b0;
  endtask

  task automatic drain_busy();
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) break;
      tick(1'b1);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_timeout: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_reset();
    logic [46:0] got;
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    got = {up_ch, up_fnumlo, up_fnumhi, up_fbcon, up_din, rhy_en, rhy_kon, am_dep,
           vib_dep, wav_en, bus.busy, group, sub, zero, slot};
    checks++;
    if (got !== {4'd0, 3'b000, 8'd0, 1'b0, 5'd0, 4'b0000, 2'd0, 3'd0, 1'b1, 18'd1}) begin
      failures++;
      $display("FAIL reset_state: got %h required %h", got,
               {4'd0, 3'b000, 8'd0, 1'b0, 5'd0, 4'b0000, 2'd0, 3'd0, 1'b1, 18'd1});
    end
  endtask

  task automatic test_slot_seq();
    logic [17:0] exp_slot;
    for (int t = 0; t < 36; t++) begin
      exp_slot = 18'd1 << (t % 18);
      checks++;
      if (slot !== exp_slot || zero !== ((t % 18) == 0) ||
          group !== 2'((t % 18) / 6) || sub !== 3'(t % 6)) begin
        failures++;
        $display("FAIL slot_seq t=%0d: slot=%h zero=%b g=%0d s=%0d required slot=%h zero=%b g=%0d s=%0d",
                 t, slot, zero, group, sub, exp_slot, (t % 18) == 0, (t % 18) / 6, t % 6);
      end
      tick(1'b1);
    end
    checks++;
    if (slot !== 18'd1 || zero !== 1'b1) begin
      failures++;
      $display("FAIL slot_wrap: slot=%h zero=%b required slot=00001 zero=1", slot, zero);
    end
  endtask

  task automatic test_fnumlo();
    int pulses;
    cpu_wr(1'b0, 8'hA3, 1'b0);
    cpu_wr(1'b1, 8'h5C, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({up_fnumlo, up_fnumhi, up_fbcon, bus.busy} !== 4'b1001) begin
        failures++;
        $display("FAIL fnumlo_hold clk=%0d: lo/hi/fb/busy=%b required 1001", i,
                 {up_fnumlo, up_fnumhi, up_fbcon, bus.busy});
      end
      tick(1'b0);
    end
    checks++;
    if (up_ch !== 4'd3 || up_din !== 8'h5C) begin
      failures++;
      $display("FAIL fnumlo_data: ch=%0d din=%h required ch=3 din=5c", up_ch, up_din);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (up_fnumlo) pulses++;
      tick(1'b1);
    end
    checks++;
    if (pulses !== 1 || up_fnumlo !== 1'b0) begin
      failures++;
      $display("FAIL fnumlo_pulse: cen pulses=%0d strobe=%b required 1 and 0", pulses, up_fnumlo);
    end
    drain_busy();
  endtask

  task automatic test_busy_block();
    cpu_wr(1'b0, 8'hB2, 1'b0);
    cpu_wr(1'b1, 8'h11, 1'b0);
    checks++;
    if (up_fnumhi !== 1'b1 || up_ch !== 4'd2) begin
      failures++;
      $display("FAIL fnumhi_set: strobe=%b ch=%0d required 1 and 2", up_fnumhi, up_ch);
    end
    tick(1'b1);
    tick(1'b1);
    cpu_wr(1'b0, 8'hC2, 1'b0);
    cpu_wr(1'b1, 8'h22, 1'b0);
    checks++;
    if (up_fbcon !== 1'b0 || up_din !== 8'h11 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_ignore: fbcon=%b din=%h busy=%b required 0 11 1", up_fbcon, up_din, bus.busy);
    end
    tick(1'b1);
    checks++;
    if (bus.busy !== 1'b1 || up_fbcon !== 1'b0) begin
      failures++;
      $display("FAIL busy_cen3: busy=%b fbcon=%b required 1 0", bus.busy, up_fbcon);
    end
    tick(1'b1);
    checks++;
    if (bus.busy !== 1'b0 || up_fbcon !== 1'b0) begin
      failures++;
      $display("FAIL busy_cen4: busy=%b fbcon=%b required 0 0", bus.busy, up_fbcon);
    end
  endtask

  task automatic test_rhythm();
    cpu_wr(1'b0, 8'hBD, 1'b0);
    cpu_wr(1'b1, 8'hFF, 1'b0);
    checks++;
    if ({am_dep, vib_dep, rhy_en, rhy_kon} !== 8'hFF ||
        {up_fnumlo, up_fnumhi, up_fbcon} !== 3'b000) begin
      failures++;
      $display("FAIL rhy_ff: am/vib/en/kon=%h strobes=%b required ff 000",
               {am_dep, vib_dep, rhy_en, rhy_kon}, {up_fnumlo, up_fnumhi, up_fbcon});
    end
    drain_busy();
    cpu_wr(1'b1, 8'h8A, 1'b0);
    checks++;
    if (am_dep !== 1'b1 || vib_dep !== 1'b0 || rhy_en !== 1'b0 || rhy_kon !== 5'h0A) begin
      failures++;
      $display("FAIL rhy_8a: am=%b vib=%b en=%b kon=%h required 1 0 0 0a",
               am_dep, vib_dep, rhy_en, rhy_kon);
    end
    drain_busy();
  endtask

  task automatic test_other_addr();
    cpu_wr(1'b0, 8'hA9, 1'b0);
    cpu_wr(1'b1, 8'h12, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.busy !== 1'b1 || {up_fnumlo, up_fnumhi, up_fbcon} !== 3'b000) begin
        failures++;
        $display("FAIL other_busy cen=%0d: busy=%b strobes=%b required 1 000", i, bus.busy,
                 {up_fnumlo, up_fnumhi, up_fbcon});
      end
      tick(1'b1);
    end
    checks++;
    if (bus.busy !== 1'b1 || up_ch !== 4'd9 || up_din !== 8'h12) begin
      failures++;
      $display("FAIL other_hold: busy=%b ch=%0d din=%h required 1 9 12", bus.busy, up_ch, up_din);
    end
    tick(1'b1);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL other_release: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid_write();
    tick(1'b1);
    tick(1'b1);
    cpu_wr(1'b0, 8'hC0, 1'b0);
    cpu_wr(1'b1, 8'h77, 1'b0);
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    checks++;
    if (up_fbcon !== 1'b0 || bus.busy !== 1'b0 || slot !== 18'd1 || zero !== 1'b1 ||
        am_dep !== 1'b0 || up_din !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid: fbcon=%b busy=%b slot=%h zero=%b am=%b din=%h required 0 0 00001 1 0 00",
               up_fbcon, bus.busy, slot, zero, am_dep, up_din);
    end
    for (int i = 0; i < 3; i++) tick(1'b1);
    checks++;
    if (up_fbcon !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_late: fbcon=%b required 0", up_fbcon);
    end
  endtask

  task automatic test_wavsel();
    logic exp_wav;
`ifdef JTOPL_WAVSEL_EN
    exp_wav = 1'b1;
`else
    exp_wav = 1'b0;
`endif
    cpu_wr(1'b0, 8'h01, 1'b0);
    cpu_wr(1'b1, 8'h20, 1'b0);
    checks++;
    if (wav_en !== exp_wav || {up_fnumlo, up_fnumhi, up_fbcon} !== 3'b000 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL wavsel: wav_en=%b strobes=%b busy=%b required %b 000 1", wav_en,
               {up_fnumlo, up_fnumhi, up_fbcon}, bus.busy, exp_wav);
    end
    drain_busy();
  endtask

  initial begin
    rst      = 1'b1;
    cen      = 1'b0;
    bus.wr_n = 1'b1;
    bus.addr = 1'b0;
    bus.din  = 8'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_slot_seq();
    test_fnumlo();
    test_busy_block();
    test_rhythm();
    test_other_addr();
    test_reset_mid_write();
    test_wavsel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
